// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse shift-and-add-3
// (shift right, then subtract 3 from every BCD digit that is 8 or more).
module bcd_to_bin #(
  parameter int NDIG      = 4,
  parameter int NBITS     = 14,
  parameter int DONE_HOLD = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              INIT,
  input  logic [4*NDIG-1:0] BCD_IN,
  output logic [NBITS-1:0]  BIN_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int WRW = 4*NDIG + NBITS;
  localparam int CW  = $clog2(NBITS + 1);
  localparam int HW  = $clog2(DONE_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ADJ,
    S_END
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WRW-1:0] wr;
  logic [WRW-1:0] wr_adj;
  logic [CW-1:0]  cnt;
  logic [HW-1:0]  hc;
  logic           bad_digit;
  logic [3:0]     digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (BCD_IN[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Digits adjust independently in 4-bit arithmetic; no borrow crosses a digit.
  always_comb begin
    wr_adj = wr;
    digit  = '0;
    for (int i = 0; i < NDIG; i++) begin
      digit = wr[NBITS + 4*i +: 4];
      if (digit >= 4'd8) wr_adj[NBITS + 4*i +: 4] = digit - 4'd3;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (INIT) state_nxt = bad_digit ? S_END : S_SHIFT;
      S_SHIFT: state_nxt = S_ADJ;
      S_ADJ:   state_nxt = (cnt == '0) ? S_END : S_SHIFT;
      S_END:   if (hc == HW'(DONE_HOLD - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr      <= '0;
      cnt     <= '0;
      hc      <= '0;
      BIN_OUT <= '0;
      ERR     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (INIT) begin
            if (bad_digit) begin
              ERR     <= 1'b1;
              BIN_OUT <= '0;
              hc      <= '0;
            end else begin
              wr  <= {BCD_IN, {NBITS{1'b0}}};
              cnt <= CW'(NBITS);
              ERR <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          wr  <= wr >> 1;
          cnt <= cnt - CW'(1);
        end
        S_ADJ: begin
          wr <= wr_adj;
          if (cnt == '0) begin
            BIN_OUT <= wr_adj[NBITS-1:0];
            hc      <= '0;
          end
        end
        S_END: hc <= hc + HW'(1);
        default: ;
      endcase
    end
  end

  assign DONE = (state == S_END);
  assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: vector table plus scoreboard checked
// whenever DONE rises, with hand-written sequences for the timing corners.
module tb_bcd_to_bin;

  logic        CLK;
  logic        RST_N;
  logic        INIT;
  logic [15:0] BCD_IN;
  logic [13:0] BIN_OUT;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  bcd_to_bin #(.NDIG(4), .NBITS(14), .DONE_HOLD(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .INIT(INIT), .BCD_IN(BCD_IN),
    .BIN_OUT(BIN_OUT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        err;
  } vec_t;

  typedef struct {
    int          acc;
    int          lat;
    logic [13:0] bin;
    logic        err;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic donePrev = 1'b0;
  int   riseCyc = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [13:0] bcdValue(input logic [15:0] b);
    int v;
    v = b[15:12]*1000 + b[11:8]*100 + b[7:4]*10 + b[3:0];
    return 14'(v);
  endfunction

  // Scoreboard: each DONE rise consumes one expected result.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (RST_N) begin
      if (DONE && !donePrev) begin
        riseCyc = cyc;
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_latency", 32'(cyc - e.acc), 32'(e.lat));
          checkOutput("bin_out", 32'(BIN_OUT), 32'(e.bin));
          checkOutput("err", 32'(ERR), 32'(e.err));
          checkOutput("busy_at_done", 32'(BUSY), 32'd1);
        end
      end
      if (!DONE && donePrev) begin
        checkOutput("done_width", 32'(cyc - riseCyc), 32'd32);
        checkOutput("busy_after_done", 32'(BUSY), 32'd0);
      end
    end
    donePrev = DONE;
  end

  task automatic waitIdle();
    int n = 0;
    @(negedge CLK);
    while (BUSY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("idle_timeout", 32'(BUSY), 32'd0);
  endtask

  task automatic applyStimulus(input logic [15:0] bcd, input logic [13:0] bin, input logic err);
    exp_t e;
    @(negedge CLK);
    INIT   = 1'b1;
    BCD_IN = bcd;
    e.acc = cyc + 1;
    e.lat = err ? 0 : 28;
    e.bin = bin;
    e.err = err;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    checkOutput("busy_on_accept", 32'(BUSY), 32'd1);
    checkOutput("err_on_accept", 32'(ERR), 32'(err));
    if (err) checkOutput("bin_zero_on_err", 32'(BIN_OUT), 32'd0);
    @(negedge CLK);
    INIT   = 1'b0;
    BCD_IN = 16'($urandom);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bin"}, 32'(BIN_OUT), 32'd0);
    checkOutput({tag, "_busy"}, 32'(BUSY), 32'd0);
    checkOutput({tag, "_done"}, 32'(DONE), 32'd0);
    checkOutput({tag, "_err"}, 32'(ERR), 32'd0);
  endtask

  initial begin
    logic [15:0] rb;
    int          n;

    vecs[0] = '{16'h9999, 14'd9999, 1'b0};
    vecs[1] = '{16'h1234, 14'd1234, 1'b0};
    vecs[2] = '{16'h0000, 14'd0,    1'b0};
    vecs[3] = '{16'h12A4, 14'd0,    1'b1};
    vecs[4] = '{16'h0007, 14'd7,    1'b0};

    RST_N  = 1'b0;
    INIT   = 1'b0;
    BCD_IN = 16'h0000;
    #12;
    checkAllZero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].bcd, vecs[i].bin, vecs[i].err);
      waitIdle();
    end

    for (int i = 0; i < 4; i++) begin
      rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      applyStimulus(rb, bcdValue(rb), 1'b0);
      waitIdle();
    end

    // INIT re-pulsed at edge 10 with a different operand must be ignored.
    applyStimulus(16'h0500, 14'd500, 1'b0);
    repeat (9) @(negedge CLK);
    INIT   = 1'b1;
    BCD_IN = 16'h9999;
    @(negedge CLK);
    INIT = 1'b0;
    waitIdle();

    // Asynchronous reset between edges 15 and 16 of a conversion.
    @(negedge CLK);
    INIT   = 1'b1;
    BCD_IN = 16'h0123;
    @(negedge CLK);
    INIT = 1'b0;
    repeat (14) @(negedge CLK);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    applyStimulus(16'h0042, 14'd42, 1'b0);
    waitIdle();

    // INIT held high: back-to-back conversions one idle cycle apart.
    begin
      exp_t e;
      @(negedge CLK);
      INIT   = 1'b1;
      BCD_IN = 16'h0099;
      e.acc = cyc + 1;
      e.lat = 28;
      e.bin = 14'd99;
      e.err = 1'b0;
      sb.push_back(e);
      e.acc = e.acc + 61;
      sb.push_back(e);
    end
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    INIT = 1'b0;
    checkOutput("held_init_results", 32'(sb.size()), 32'd0);
    waitIdle();
    repeat (2) @(negedge CLK);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
